// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit.
// Shift-add multiply and restoring divide, one bit per cycle.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [2*XLEN-1:0] r_acc;
  logic              r_neg;
  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_result;

  logic              w_is_div;
  logic              w_sgn_a;
  logic              w_sgn_b;
  logic              w_neg_a;
  logic              w_neg_b;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic              w_div0;
  logic              w_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_special_res;
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_step;
  logic [XLEN:0]     w_div_trial;
  logic [2*XLEN-1:0] w_div_step;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_res;

  assign w_is_div = r_op[2];
  assign w_sgn_a  = (r_op == 3'b001) || (r_op == 3'b010) ||
                    (r_op == 3'b100) || (r_op == 3'b110);
  assign w_sgn_b  = (r_op == 3'b001) || (r_op == 3'b100) ||
                    (r_op == 3'b110);
  assign w_neg_a  = w_sgn_a && r_a[XLEN-1];
  assign w_neg_b  = w_sgn_b && r_b[XLEN-1];
  assign w_mag_a  = w_neg_a ? -r_a : r_a;
  assign w_mag_b  = w_neg_b ? -r_b : r_b;

  assign w_div0    = w_is_div && (r_b == '0);
  assign w_ovf     = w_is_div && !r_op[0] &&
                     (r_a == MIN_NEG) && (r_b == '1);
  assign w_special = w_div0 || w_ovf;

  always_comb begin
    w_special_res = '0;
    if (w_div0) begin
      w_special_res = r_op[1] ? r_a : '1;
    end else if (w_ovf) begin
      w_special_res = r_op[1] ? '0 : r_a;
    end
  end

  // Multiply: low half holds the multiplier, shifted out LSB first.
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_b};
  assign w_mul_step = r_acc[0] ?
                      {w_mul_sum, r_acc[XLEN-1:1]} :
                      {1'b0, r_acc[2*XLEN-1:1]};

  // Divide: {remainder, dividend/quotient}, quotient bits fill from LSB.
  assign w_div_trial = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_b};
  assign w_div_step  = w_div_trial[XLEN] ?
                       {r_acc[2*XLEN-2:0], 1'b0} :
                       {w_div_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

  assign w_prod = r_neg ? -r_acc : r_acc;
  assign w_quo  = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem  = r_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_fix_res = '0;
    unique case (r_op)
      3'b000:  w_fix_res = w_prod[XLEN-1:0];
      3'b001,
      3'b010,
      3'b011:  w_fix_res = w_prod[2*XLEN-1:XLEN];
      3'b100,
      3'b101:  w_fix_res = w_quo;
      3'b110,
      3'b111:  w_fix_res = w_rem;
      default: w_fix_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (kill) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (start) w_next = S_PREP;
        S_PREP:  w_next = w_special ? S_DONE : S_CALC;
        S_CALC:  if (r_cnt == '0) w_next = S_FIX;
        S_FIX:   w_next = S_DONE;
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (!kill) begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op <= funct3;
            r_a  <= a;
            r_b  <= b;
          end
        end
        S_PREP: begin
          r_acc <= {{XLEN{1'b0}}, w_mag_a};
          r_b   <= w_mag_b;
          r_neg <= (r_op[2] && r_op[1]) ? w_neg_a : (w_neg_a ^ w_neg_b);
          r_cnt <= CW'(XLEN - 1);
          if (w_special) r_result <= w_special_res;
        end
        S_CALC: begin
          r_acc <= w_is_div ? w_div_step : w_mul_step;
          r_cnt <= r_cnt - 1'b1;
        end
        S_FIX: begin
          r_result <= w_fix_res;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;

endmodule
